eq_sweep_checker: RTL and testbench



---
 rtl/eq_sweep_pkg.sv | 17 +
 rtl/eq_sweep_checker_if.sv | 27 ++
 rtl/eq_sweep_settle_timer.sv | 30 +++
 rtl/eq_sweep_checker.sv | 124 ++++++++++++
 tb/tb_eq_sweep_checker.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/eq_sweep_pkg.sv
// Shared types and helpers for the equality-comparator sweep exerciser.
// The sweep-length helper is used by both the design and its bench.
package eq_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Cycles from the start edge to the last CHECK cycle inclusive; DONE follows.
    function automatic int unsigned sweep_cycles(input int unsigned n, input int unsigned settle);
        return (32'd1 << (2 * n)) * (settle + 32'd1);
    endfunction

endpackage

// File: rtl/eq_sweep_checker_if.sv
// Bundle between the sweep checker (master) and the comparator/host side (slave).
// start and eq_in are sampled on clk; all other signals are registered or state-decoded.
interface eq_sweep_checker_if #(parameter int N = 2);

    logic                   start;
    logic [N-1:0]           a_out;
    logic [N-1:0]           b_out;
    logic                   eq_in;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [2*N:0]           err_cnt;
    logic [N-1:0]           fail_a;
    logic [N-1:0]           fail_b;
    eq_sweep_pkg::state_t   state;

    modport master (
        input  start, eq_in,
        output a_out, b_out, busy, done, pass, err_cnt, fail_a, fail_b, state
    );

    modport slave (
        output start, eq_in,
        input  a_out, b_out, busy, done, pass, err_cnt, fail_a, fail_b, state
    );

endinterface

// File: rtl/eq_sweep_settle_timer.sv
// Down-counter holding each vector for SETTLE cycles; i_load arms it for a new vector.
// o_expire is high in the last DRIVE cycle of the current vector.
module eq_sweep_settle_timer #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);

    localparam int W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [W-1:0] LOAD_VAL = W'(SETTLE - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/eq_sweep_checker.sv
// Sweeps every (a,b) operand pair into an N-bit equality comparator and counts
// disagreements between its eq output and the golden a==b result.
module eq_sweep_checker
    import eq_sweep_pkg::*;
#(
    parameter int N      = 2,
    parameter int SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    eq_sweep_checker_if.master    bus
);

    state_t           r_state;
    state_t           w_next;
    logic [2*N-1:0]   r_vec;
    logic [2*N:0]     r_err_cnt;
    logic [N-1:0]     r_fail_a;
    logic [N-1:0]     r_fail_b;
    logic             r_pass;

    logic             w_load;
    logic             w_expire;
    logic             w_exp;
    logic             w_mis;
    logic             w_last;
    logic [2*N:0]     w_err_next;

    eq_sweep_settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_load),
        .i_en     (r_state == DRIVE),
        .o_expire (w_expire)
    );

    assign w_exp      = (r_vec[2*N-1:N] == r_vec[N-1:0]);
    assign w_mis      = (bus.eq_in != w_exp);
    assign w_last     = (r_vec == '1);
    assign w_err_next = r_err_cnt + (2*N+1)'(w_mis);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next = DRIVE;
                    w_load = 1'b1;
                end
            end
            DRIVE: begin
                if (w_expire) begin
                    w_next = CHECK;
                end
            end
            CHECK: begin
                if (w_last) begin
                    w_next = DONE;
                end else begin
                    w_next = DRIVE;
                    w_load = 1'b1;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // pass is resolved on entry to DONE so it is already valid alongside the done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vec     <= '0;
            r_err_cnt <= '0;
            r_fail_a  <= '0;
            r_fail_b  <= '0;
            r_pass    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_vec     <= '0;
                        r_err_cnt <= '0;
                        r_fail_a  <= '0;
                        r_fail_b  <= '0;
                        r_pass    <= 1'b0;
                    end
                end
                CHECK: begin
                    r_err_cnt <= w_err_next;
                    if (w_mis && (r_err_cnt == '0)) begin
                        r_fail_a <= r_vec[2*N-1:N];
                        r_fail_b <= r_vec[N-1:0];
                    end
                    if (w_last) begin
                        r_pass <= (w_err_next == '0);
                    end else begin
                        r_vec <= r_vec + (2*N)'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.a_out   = r_vec[2*N-1:N];
    assign bus.b_out   = r_vec[N-1:0];
    assign bus.busy    = (r_state == DRIVE) || (r_state == CHECK);
    assign bus.done    = (r_state == DONE);
    assign bus.pass    = r_pass;
    assign bus.err_cnt = r_err_cnt;
    assign bus.fail_a  = r_fail_a;
    assign bus.fail_b  = r_fail_b;
    assign bus.state   = r_state;

endmodule

// File: tb/tb_eq_sweep_checker.sv
// Bench for eq_sweep_checker: two instances (SETTLE=1 and SETTLE=3) driven by a
// behavioural comparator whose fault mode is selected per test.
module tb_eq_sweep_checker;
    import eq_sweep_pkg::*;

    localparam int N = 2;

    logic clk = 1'b0;
    logic reset;
    logic r_start;
    int   sel;
    int   mode;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    eq_sweep_checker_if #(.N(N)) if1 ();
    eq_sweep_checker_if #(.N(N)) if3 ();

    eq_sweep_checker #(.N(N), .SETTLE(1)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));
    eq_sweep_checker #(.N(N), .SETTLE(3)) u_dut3 (.clk(clk), .reset(reset), .bus(if3));

    // mode 0: correct, 1: stuck at 0, 2: stuck at 1, 3: inverted
    function automatic logic cmp_model(input int m, input logic [N-1:0] a, input logic [N-1:0] b);
        case (m)
            0:       return (a == b);
            1:       return 1'b0;
            2:       return 1'b1;
            default: return (a != b);
        endcase
    endfunction

    assign if1.start = r_start && (sel == 0);
    assign if3.start = r_start && (sel == 1);
    assign if1.eq_in = cmp_model(mode, if1.a_out, if1.b_out);
    assign if3.eq_in = cmp_model(mode, if3.a_out, if3.b_out);

    logic           w_busy, w_done, w_pass;
    logic [2*N:0]   w_err;
    logic [N-1:0]   w_a, w_b, w_fa, w_fb;

    always_comb begin
        w_busy = if1.busy;
        w_done = if1.done;
        w_pass = if1.pass;
        w_err  = if1.err_cnt;
        w_a    = if1.a_out;
        w_b    = if1.b_out;
        w_fa   = if1.fail_a;
        w_fb   = if1.fail_b;
        if (sel == 1) begin
            w_busy = if3.busy;
            w_done = if3.done;
            w_pass = if3.pass;
            w_err  = if3.err_cnt;
            w_a    = if3.a_out;
            w_b    = if3.b_out;
            w_fa   = if3.fail_a;
            w_fb   = if3.fail_b;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pulses start for one cycle, then follows the sweep to its done pulse.
    task automatic run_sweep(input string tag, input int settle, input int exp_err,
                             input int exp_pass, input int exp_fa, input int exp_fb);
        int lat;
        int j;
        int done_at;
        int busy_low;
        lat      = int'(sweep_cycles(N, settle));
        done_at  = -1;
        busy_low = 0;
        @(negedge clk) r_start = 1'b1;
        @(negedge clk) r_start = 1'b0;
        j = 1;
        while (done_at < 0 && j <= lat + 20) begin
            if (w_done) begin
                done_at = j;
            end else begin
                if (j <= lat && !w_busy) busy_low++;
                @(negedge clk);
                j++;
            end
        end
        check({tag, " done_latency"}, done_at, lat + 1);
        check({tag, " busy_gaps"}, busy_low, 0);
        check({tag, " busy_in_done"}, int'(w_busy), 0);
        check({tag, " err_cnt"}, int'(w_err), exp_err);
        check({tag, " pass"}, int'(w_pass), exp_pass);
        check({tag, " fail_a"}, int'(w_fa), exp_fa);
        check({tag, " fail_b"}, int'(w_fb), exp_fb);
        @(negedge clk);
        check({tag, " done_one_cycle"}, int'(w_done), 0);
        check({tag, " pass_hold"}, int'(w_pass), exp_pass);
    endtask

    typedef struct {
        string name;
        int    sel;
        int    mode;
        int    err;
        int    pass;
        int    fa;
        int    fb;
    } vec_t;

    vec_t tbl[4];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int n_done;

        tbl[0] = '{"correct",  0, 0, 0,  1, 0, 0};
        tbl[1] = '{"stuck0",   0, 1, 4,  0, 0, 0};
        tbl[2] = '{"stuck1",   0, 2, 12, 0, 0, 1};
        tbl[3] = '{"inverted", 1, 3, 16, 0, 0, 0};

        reset   = 1'b1;
        r_start = 1'b0;
        sel     = 0;
        mode    = 0;
        repeat (3) @(negedge clk);
        check("rst busy",    int'(if1.busy) + int'(if3.busy), 0);
        check("rst done",    int'(if1.done) + int'(if3.done), 0);
        check("rst pass",    int'(if1.pass) + int'(if3.pass), 0);
        check("rst err_cnt", int'(if1.err_cnt) + int'(if3.err_cnt), 0);
        check("rst a_b",     int'(if1.a_out) + int'(if1.b_out) + int'(if3.a_out) + int'(if3.b_out), 0);
        check("rst fail_ab", int'(if1.fail_a) + int'(if1.fail_b) + int'(if3.fail_a) + int'(if3.fail_b), 0);
        check("rst state",   int'(if1.state), int'(IDLE));
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sel  = tbl[i].sel;
            mode = tbl[i].mode;
            run_sweep(tbl[i].name, (tbl[i].sel == 1) ? 3 : 1, tbl[i].err, tbl[i].pass,
                      tbl[i].fa, tbl[i].fb);
        end

        // Reset in the middle of a sweep, while vector 5 (a=01,b=01) is driven.
        sel  = 0;
        mode = 1;
        @(negedge clk) r_start = 1'b1;
        @(negedge clk) r_start = 1'b0;
        cnt = 0;
        while (!(w_a == 2'd1 && w_b == 2'd1) && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("midrst reached_vec5", int'(cnt < 100), 1);
        check("midrst err_before", int'(w_err), 1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst busy",    int'(w_busy), 0);
        check("midrst a_out",   int'(w_a), 0);
        check("midrst b_out",   int'(w_b), 0);
        check("midrst err_cnt", int'(w_err), 0);
        check("midrst done",    int'(w_done), 0);
        reset  = 1'b0;
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (w_done) n_done++;
        end
        check("midrst no_done", n_done, 0);
        mode = 0;
        run_sweep("restart", 1, 0, 1, 0, 0);

        // start held high: one sweep, one done pulse, restart only out of IDLE.
        sel    = 0;
        mode   = 2;
        n_done = 0;
        @(negedge clk) r_start = 1'b1;
        for (int j = 1; j <= int'(sweep_cycles(N, 1)) + 1; j++) begin
            @(negedge clk);
            if (w_done) n_done++;
        end
        check("held done_count", n_done, 1);
        check("held done_at_end", int'(w_done), 1);
        check("held err_cnt", int'(w_err), 12);
        @(negedge clk);
        check("held idle_busy", int'(w_busy), 0);
        check("held idle_err_hold", int'(w_err), 12);
        check("held idle_pass_hold", int'(w_pass), 0);
        @(negedge clk);
        check("held restart_busy", int'(w_busy), 1);
        check("held restart_err_clr", int'(w_err), 0);
        r_start = 1'b0;
        cnt = 0;
        while (!w_done && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("held second_done", int'(w_done), 1);
        check("held second_err", int'(w_err), 12);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
